// File: rtl/spi_slave_pkg.sv
// Shared types and default sizes for the SPI slave and its synchronizer.
package spi_slave_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus signal, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_slave_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= {SYNC_STAGES{RESET_VAL}};
            sync_d <= RESET_VAL;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], din};
            sync_d <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, MSB-first, oversampled in the clk domain.
// Define SPI_SLAVE_ECHO_EN to echo the last received byte instead of 0x00 on underrun.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_byte,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              state_dbg
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_e        state;
    spi_mode_t         mode;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] buf_data;
    logic              byte_done;

    logic sck_rise, sck_fall, ss_s, mosi_s;
    logic sck_sync_unused, ss_rise_unused, ss_fall_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck),
        .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss),
        .sync(ss_s), .rise(ss_rise_unused), .fall(ss_fall_unused)
    );

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Leading edge leaves the latched idle level; cpha picks which edge samples.
    logic lead_edge, trail_edge, sample_edge, shift_edge, last_sample;

    always_comb begin
        lead_edge   = mode.cpol ? sck_fall : sck_rise;
        trail_edge  = mode.cpol ? sck_rise : sck_fall;
        sample_edge = mode.cpha ? trail_edge : lead_edge;
        shift_edge  = mode.cpha ? lead_edge : trail_edge;
        last_sample = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));
    end

    // Byte handed to the shift register at frame entry or byte completion.
    logic [DATA_W-1:0] load_val;
    logic              load_underrun;

    always_comb begin
        load_val      = buf_data;
        load_underrun = 1'b0;
        if (tx_ready) begin
`ifdef SPI_SLAVE_ECHO_EN
            load_val = byte_done ? rx_sh : rx_byte;
`else
            load_val      = '0;
            load_underrun = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode        <= MODE0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            buf_data    <= '0;
            byte_done   <= 1'b0;
            miso        <= 1'b0;
            tx_ready    <= 1'b1;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;

            // tx_ready doubles as the "buffer empty" flag.
            if (tx_valid && tx_ready) begin
                buf_data <= tx_byte;
                tx_ready <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!ss_s) begin
                        state       <= ST_ACTIVE;
                        busy        <= 1'b1;
                        mode        <= {cpol, cpha};
                        bit_cnt     <= '0;
                        byte_done   <= 1'b0;
                        rx_sh       <= '0;
                        tx_underrun <= load_underrun;
                        if (!tx_ready) tx_ready <= 1'b1;
                        if (!cpha) begin
                            miso  <= load_val[DATA_W-1];
                            tx_sh <= {load_val[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_sh <= load_val;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (byte_done) begin
                        byte_done   <= 1'b0;
                        rx_byte     <= rx_sh;
                        rx_valid    <= 1'b1;
                        bit_cnt     <= '0;
                        tx_sh       <= load_val;
                        tx_underrun <= load_underrun;
                        if (!tx_ready) tx_ready <= 1'b1;
                    end else if (ss_s && !last_sample) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        miso    <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) frame_err <= 1'b1;
                    end else begin
                        // A last sample coinciding with ss rise still completes the byte.
                        if (sample_edge) begin
                            rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_sample) byte_done <= 1'b1;
                        end
                        if (shift_edge) begin
                            miso  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, vector table, rx scoreboard.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int HP = 4;   // master sck half-period in clk cycles

`ifdef SPI_SLAVE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0;
    logic       sck = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, tx_ready, rx_valid, busy, tx_underrun, frame_err, state_dbg;
    logic [7:0] rx_byte;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .state_dbg(state_dbg)
    );

    int         n_vec = 0, n_err = 0;
    int         rv_cnt = 0, und_cnt = 0, fe_cnt = 0;
    logic       rv_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] m_tx[2];
    logic [7:0] m_rx[2];
    logic [7:0] last_rx = 8'h00;

    typedef struct {
        spi_mode_t  mode;
        logic       preload;
        logic [7:0] stx;
        logic [7:0] mtx;
        logic [7:0] exp_mrx;
        int         exp_und;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 200) begin
            wait_clk(1);
            t++;
        end
        if (!tx_ready) fail("tx_ready_wait");
        tx_byte  = b;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!busy && t < 100) begin
            wait_clk(1);
            t++;
        end
        if (!busy) fail("busy_wait");
    endtask

    task automatic master_frame(input spi_mode_t m, input int nbits);
        cpol = m.cpol;
        cpha = m.cpha;
        sck  = m.cpol;
        wait_clk(HP);
        ss = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (!m.cpha) begin
                mosi = m_tx[b / 8][7 - (b % 8)];
                wait_clk(HP);
                m_rx[b / 8][7 - (b % 8)] = miso;
                sck = ~m.cpol;
                wait_clk(HP);
                sck = m.cpol;
            end else begin
                wait_clk(HP);
                sck  = ~m.cpol;
                mosi = m_tx[b / 8][7 - (b % 8)];
                wait_clk(HP);
                m_rx[b / 8][7 - (b % 8)] = miso;
                sck = m.cpol;
            end
        end
        wait_clk(HP);
        ss   = 1'b1;
        mosi = 1'b0;
        wait_clk(HP);
    endtask

    task automatic run_vec(input vec_t v);
        int rv0 = rv_cnt, und0 = und_cnt, fe0 = fe_cnt;
        if (v.preload) begin
            load_tx(v.stx);
            check("tx_ready_full", tx_ready, 0);
        end else begin
            check("tx_ready_empty", tx_ready, 1);
        end
        m_tx[0] = v.mtx;
        exp_q.push_back(v.mtx);
        master_frame(v.mode, 8);
        wait_clk(2);
        check("master_rx", m_rx[0], v.exp_mrx);
        check("rx_byte_hold", rx_byte, v.mtx);
        check("rx_valid_count", rv_cnt - rv0, 1);
        check("underrun_count", und_cnt - und0, v.exp_und);
        check("frame_err_count", fe_cnt - fe0, 0);
        check("tx_ready_after", tx_ready, 1);
        check("busy_after", busy, 0);
        check("miso_after", miso, 0);
        last_rx = v.mtx;
    endtask

    // Scoreboard side: every rx_valid strobe pops one expected byte.
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt++;
            check("rx_valid_width", rv_prev, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_unexpected: got %0h, want no strobe", rx_byte);
            end else begin
                check("rx_byte_sb", rx_byte, exp_q.pop_front());
            end
        end
        if (tx_underrun) und_cnt++;
        if (frame_err) fe_cnt++;
        rv_prev = rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0, und0, fe0;

        vecs[0] = '{MODE0, 1'b1, 8'hA5, 8'h3C, 8'hA5, ECHO ? 0 : 1};
        vecs[1] = '{MODE1, 1'b1, 8'h81, 8'h7E, 8'h81, ECHO ? 0 : 1};
        vecs[2] = '{MODE2, 1'b1, 8'h81, 8'h7E, 8'h81, ECHO ? 0 : 1};
        vecs[3] = '{MODE3, 1'b1, 8'h81, 8'h7E, 8'h81, ECHO ? 0 : 1};
        vecs[4] = '{MODE0, 1'b0, 8'h00, 8'h55, ECHO ? 8'h7E : 8'h00, ECHO ? 0 : 2};
        vecs[5] = '{MODE0, 1'b0, 8'h00, 8'h0F, ECHO ? 8'h55 : 8'h00, ECHO ? 0 : 2};
        for (int i = 6; i < 9; i++) begin
            vecs[i].mode    = 2'($urandom_range(0, 3));
            vecs[i].preload = 1'b1;
            vecs[i].stx     = 8'($urandom_range(0, 255));
            vecs[i].mtx     = 8'($urandom_range(0, 255));
            vecs[i].exp_mrx = vecs[i].stx;
            vecs[i].exp_und = ECHO ? 0 : 1;
        end

        // Reset state
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        wait_clk(HP);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Two bytes in one frame, buffer refilled while the first byte shifts;
        // mode inputs are also toggled mid-frame and must be ignored.
        rv0 = rv_cnt; und0 = und_cnt; fe0 = fe_cnt;
        load_tx(8'hE7);
        m_tx[0] = 8'h11;
        m_tx[1] = 8'h22;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            master_frame(MODE0, 16);
            begin
                wait_busy();
                cpol = 1'b1;
                cpha = 1'b1;
                load_tx(8'hC3);
            end
        join
        wait_clk(2);
        check("b2b_master_rx0", m_rx[0], 8'hE7);
        check("b2b_master_rx1", m_rx[1], 8'hC3);
        check("b2b_rx_valid_count", rv_cnt - rv0, 2);
        check("b2b_underrun_count", und_cnt - und0, ECHO ? 0 : 1);
        check("b2b_frame_err_count", fe_cnt - fe0, 0);
        check("b2b_rx_byte", rx_byte, 8'h22);
        last_rx = 8'h22;

        // ss rises after three bits: frame error, rx_byte unchanged.
        rv0 = rv_cnt; und0 = und_cnt; fe0 = fe_cnt;
        load_tx(8'h99);
        m_tx[0] = 8'hF0;
        master_frame(MODE0, 3);
        wait_clk(2);
        check("abort_frame_err_count", fe_cnt - fe0, 1);
        check("abort_rx_valid_count", rv_cnt - rv0, 0);
        check("abort_underrun_count", und_cnt - und0, 0);
        check("abort_rx_byte", rx_byte, last_rx);
        check("abort_busy", busy, 0);
        run_vec('{MODE0, 1'b1, 8'h6B, 8'h96, 8'h6B, ECHO ? 0 : 1});

        // Reset in the middle of a byte: silent abort.
        rv0 = rv_cnt; und0 = und_cnt; fe0 = fe_cnt;
        load_tx(8'h5A);
        m_tx[0] = 8'hFF;
        fork
            master_frame(MODE0, 4);
            begin
                wait_clk(22);
                check("mid_busy", busy, 1);
                rst = 1'b1;
                wait_clk(1);
                check("mid_rst_miso", miso, 0);
                check("mid_rst_tx_ready", tx_ready, 1);
                check("mid_rst_rx_byte", rx_byte, 0);
                check("mid_rst_rx_valid", rx_valid, 0);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_underrun", tx_underrun, 0);
                check("mid_rst_frame_err", frame_err, 0);
                check("mid_rst_state", state_dbg, ST_IDLE);
            end
        join
        wait_clk(2);
        rst = 1'b0;
        wait_clk(HP);
        check("mid_rst_rx_valid_count", rv_cnt - rv0, 0);
        check("mid_rst_frame_err_count", fe_cnt - fe0, 0);
        check("mid_rst_underrun_count", und_cnt - und0, 0);
        last_rx = 8'h00;
        run_vec('{MODE1, 1'b1, 8'h24, 8'hDB, 8'h24, ECHO ? 0 : 1});

        wait_clk(4);
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
